// File: rtl/decode_writeback.sv
// SEQ Y86-64 decode/write-back stage: index decode, 15x64 register file with
// combinational reads, edge-committed write-back and a sticky halt flag.
module decode_writeback #(
  parameter logic [3:0] RSP_IDX  = 4'd4,
  parameter logic [3:0] NONE_IDX = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  output logic [3:0]  srcA,
  output logic [3:0]  srcB,
  output logic [3:0]  dstE,
  output logic [3:0]  dstM,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic        halted,
  input  logic [3:0]  dbg_idx,
  output logic [63:0] dbg_data
);

  localparam int unsigned XLEN  = 64;
  localparam int unsigned NREGS = 15;
  localparam int unsigned NIDX  = 16;

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OP    = 4'h6;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic                       halted_q, halted_d;
  logic [NIDX-1:0][XLEN-1:0]  rd_view;

  // Register index decode per instruction class
  always_comb begin
    srcA = NONE_IDX;
    srcB = NONE_IDX;
    dstE = NONE_IDX;
    dstM = NONE_IDX;
    case (icode)
      I_CMOV: begin
        srcA = rA;
        dstE = cnd ? rB : NONE_IDX;
      end
      I_IRMOV: begin
        dstE = rB;
      end
      I_RMMOV: begin
        srcA = rA;
        srcB = rB;
      end
      I_MRMOV: begin
        srcB = rB;
        dstM = rA;
      end
      I_OP: begin
        srcA = rA;
        srcB = rB;
        dstE = rB;
      end
      I_CALL: begin
        srcB = RSP_IDX;
        dstE = RSP_IDX;
      end
      I_RET: begin
        srcA = RSP_IDX;
        srcB = RSP_IDX;
        dstE = RSP_IDX;
      end
      I_PUSH: begin
        srcA = rA;
        srcB = RSP_IDX;
        dstE = RSP_IDX;
      end
      I_POP: begin
        srcA = RSP_IDX;
        srcB = RSP_IDX;
        dstE = RSP_IDX;
        dstM = rA;
      end
      default: begin
        srcA = NONE_IDX;
      end
    endcase
  end

  // Index F maps onto a constant zero slot so reads never go out of range
  assign rd_view  = {{XLEN{1'b0}}, regs_q};
  assign valA     = rd_view[srcA];
  assign valB     = rd_view[srcB];
  assign dbg_data = rd_view[dbg_idx];
  assign halted   = halted_q;

  // Write-back; the M port is applied last so it wins on a popq %rsp collision
  always_comb begin
    regs_d   = regs_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (icode == I_HALT) begin
        halted_d = 1'b1;
      end else begin
        for (int unsigned i = 0; i < NREGS; i++) begin
          if (dstE == 4'(i)) regs_d[i] = valE;
          if (dstM == 4'(i)) regs_d[i] = valM;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      halted_q <= halted_d;
    end
  end

endmodule

// File: tb/tb_decode_writeback.sv
// Randomized and directed checks of decode_writeback against a behavioural model.
module tb_decode_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  icode, rA, rB, dbg_idx;
  logic        cnd;
  logic [63:0] valE, valM;
  logic [3:0]  srcA, srcB, dstE, dstM;
  logic [63:0] valA, valB, dbg_data;
  logic        halted;

  int errors = 0;
  int checks = 0;

  logic [63:0] m_regs [16];
  logic        m_halted;

  decode_writeback dut (
    .clk(clk), .rst_n(rst_n), .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
    .valE(valE), .valM(valM), .srcA(srcA), .srcB(srcB), .dstE(dstE),
    .dstM(dstM), .valA(valA), .valB(valB), .halted(halted),
    .dbg_idx(dbg_idx), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] rb, input logic c);
    if (ic == 4'h2) return c ? rb : 4'hF;
    if (ic inside {4'h3, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h5, 4'hB}) return ra;
    return 4'hF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic c, input logic [63:0] ve, input logic [63:0] vm,
                       input logic rn);
    icode = ic; rA = ra; rB = rb; cnd = c; valE = ve; valM = vm; rst_n = rn;
    dbg_idx = 4'($urandom_range(0, 15));
  endtask

  // Compare every output with the model, then advance one edge and update the model
  task automatic tick();
    logic [3:0] e_sa, e_sb, e_de, e_dm;
    @(negedge clk);
    e_sa = m_srcA(icode, rA);
    e_sb = m_srcB(icode, rB);
    e_de = m_dstE(icode, rB, cnd);
    e_dm = m_dstM(icode, rA);
    check("srcA", 64'(srcA), 64'(e_sa));
    check("srcB", 64'(srcB), 64'(e_sb));
    check("dstE", 64'(dstE), 64'(e_de));
    check("dstM", 64'(dstM), 64'(e_dm));
    check("valA", valA, m_regs[e_sa]);
    check("valB", valB, m_regs[e_sb]);
    check("dbg_data", dbg_data, m_regs[dbg_idx]);
    check("halted", 64'(halted), 64'(m_halted));
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_halted = 1'b0;
    end else if (!m_halted) begin
      if (icode == 4'h0) m_halted = 1'b1;
      if (e_de != 4'hF) m_regs[e_de] = valE;
      if (e_dm != 4'hF) m_regs[e_dm] = valM;
    end
    #1;
  endtask

  task automatic peek(input logic [3:0] idx, input logic [63:0] exp, input string name);
    drive(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b1);
    dbg_idx = idx;
    #1;
    check(name, dbg_data, exp);
  endtask

  initial begin
    logic [63:0] r1_before;
    for (int i = 0; i < 16; i++) m_regs[i] = 'x;
    m_regs[15] = '0;
    m_halted = 1'bx;

    drive(4'h3, 4'h1, 4'h2, 1'b1, 64'hDEAD, 64'hBEEF, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_halted = 1'b0;
    drive(4'h6, 4'h3, 4'h3, 1'b0, 64'h55, 64'h66, 1'b0);
    tick();
    for (int i = 0; i < 16; i++) peek(4'(i), 64'd0, "reset_sweep");
    check("reset_halted", 64'(halted), 64'd0);

    drive(4'h3, 4'hF, 4'd2, 1'b0, 64'h1234, 64'h0, 1'b1);
    tick();
    peek(4'd2, 64'h1234, "irmovq_reg2");
    drive(4'h6, 4'd2, 4'd2, 1'b0, 64'h2468, 64'h0, 1'b1);
    #1;
    check("opq_srcA", 64'(srcA), 64'd2);
    check("opq_srcB", 64'(srcB), 64'd2);
    check("opq_valA", valA, 64'h1234);
    check("opq_valB", valB, 64'h1234);
    tick();

    drive(4'h2, 4'd1, 4'd5, 1'b0, 64'd7, 64'd0, 1'b1);
    #1;
    check("cmov_nt_dstE", 64'(dstE), 64'hF);
    tick();
    peek(4'd5, 64'd0, "cmov_nt_reg5");
    drive(4'h2, 4'd1, 4'd5, 1'b1, 64'd7, 64'd0, 1'b1);
    tick();
    peek(4'd5, 64'd7, "cmov_t_reg5");

    drive(4'hB, 4'd4, 4'hF, 1'b0, 64'd16, 64'd99, 1'b1);
    #1;
    check("popq_dstE", 64'(dstE), 64'd4);
    check("popq_dstM", 64'(dstM), 64'd4);
    tick();
    peek(4'd4, 64'd99, "popq_rsp");
    drive(4'hA, 4'd3, 4'hF, 1'b0, 64'd91, 64'd0, 1'b1);
    #1;
    check("pushq_srcA", 64'(srcA), 64'd3);
    check("pushq_srcB", 64'(srcB), 64'd4);
    check("pushq_valB", valB, 64'd99);
    tick();

    peek(4'd1, m_regs[1], "pre_halt_reg1");
    r1_before = dbg_data;
    drive(4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b1);
    tick();
    check("halt_set", 64'(halted), 64'd1);
    for (int k = 0; k < 3; k++) begin
      drive(4'h3, 4'hF, 4'd1, 1'b0, 64'd5, 64'd0, 1'b1);
      tick();
    end
    peek(4'd1, r1_before, "halt_reg1_frozen");
    check("halt_sticky", 64'(halted), 64'd1);
    drive(4'h3, 4'hF, 4'd1, 1'b0, 64'd5, 64'd0, 1'b0);
    tick();
    check("halt_cleared", 64'(halted), 64'd0);
    for (int i = 0; i < 16; i++) peek(4'(i), 64'd0, "post_reset_sweep");

    drive(4'h3, 4'hF, 4'd7, 1'b0, 64'd9, 64'd0, 1'b0);
    tick();
    peek(4'd7, 64'd0, "reset_mid_write");

    for (int n = 0; n < 3000; n++) begin
      logic [3:0] ic;
      ic = ($urandom_range(0, 99) < 3) ? 4'h0 : 4'($urandom_range(1, 15));
      drive(ic, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom_range(0, 99) < 4) ? 1'b0 : 1'b1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_writeback.md
# decode_writeback

Register-file stage of the SEQ Y86-64 processor, directly downstream of `fetch`. It consumes the fetched `icode`/`rA`/`rB` fields and supplies `valA`/`valB` to execute. It also commits the `valE`/`valM` write-back results into the fifteen 64-bit program registers at the clock edge. A sticky halt flag freezes architectural state once `halt` is retired.

## Interface
Parameters:
- `RSP_IDX`, default 4: register index used as the stack pointer.
- `NONE_IDX`, default 4'hF: "no register" encoding.

Ports:
- `clk`, input, 1: single system clock; all state updates on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `icode`, input, 4: instruction code from fetch.
- `rA`, input, 4: rA field from fetch.
- `rB`, input, 4: rB field from fetch.
- `cnd`, input, 1: condition result from execute (used by cmovXX).
- `valE`, input, 64: ALU result to write back.
- `valM`, input, 64: memory read result to write back.
- `srcA`, output, 4: decoded source A index.
- `srcB`, output, 4: decoded source B index.
- `dstE`, output, 4: decoded E destination index.
- `dstM`, output, 4: decoded M destination index.
- `valA`, output, 64: read data for `srcA`.
- `valB`, output, 64: read data for `srcB`.
- `halted`, output, 1: sticky halt flag.
- `dbg_idx`, input, 4: debug read index.
- `dbg_data`, output, 64: debug read data.

## Operation
Index decode is combinational:
- `srcA`:
  - `rA` for icode 2, 4, 6, A;
  - `RSP_IDX` for icode 9, B;
  - otherwise `NONE_IDX`.
- `srcB`:
  - `rB` for icode 4, 5, 6;
  - `RSP_IDX` for icode 8, 9, A, B;
  - otherwise `NONE_IDX`.
- `dstE`:
  - icode 2: `rB` if `cnd`=1, else `NONE_IDX`;
  - icode 3, 6: `rB`;
  - icode 8, 9, A, B: `RSP_IDX`;
  - otherwise `NONE_IDX`.
- `dstM`:
  - `rA` for icode 5, B;
  - otherwise `NONE_IDX`.
- Any icode above B: all four indices are `NONE_IDX`.

Register reads:
- `valA`, `valB` and `dbg_data` are combinational reads of the current (pre-edge) register contents.
- Reading index F returns 64'd0.

Write-back, at the rising edge when `rst_n`=1 and `halted`=0:
- If `dstE`≠F: `reg[dstE]` ← `valE`.
- If `dstM`≠F: `reg[dstM]` ← `valM`.
- If `dstE`==`dstM`≠F (popq %rsp): `valM` wins.

Halt:
- `halted` sets at a rising edge where `icode`==0 and `rst_n`=1.
- Once set, all writes are suppressed until reset.
- Writes in the same edge as the halt are also suppressed; icode 0 decodes no destinations anyway.

Reset:
- Registers 0–E clear to 0.
- `halted` clears to 0.
- Reset overrides any simultaneous write or halt.

## Timing
- Reset values: all registers 0, `halted`=0. Consequently `valA`=`valB`=`dbg_data`=0 after reset. Index outputs follow the inputs combinationally.
- Decode latency is zero cycles: `valA`/`valB` are valid in the same cycle as `icode`/`rA`/`rB`.
- Write latency is one edge: a value written at edge N is visible on `valA`/`valB` from edge N onward. There is no write-to-read bypass within a cycle.
- Holding `rst_n` low for several cycles keeps the state cleared. Asserting reset mid-program discards that cycle's write.
- Inputs change after the rising edge; a bench samples outputs before the next rising edge.

## Test plan
- Reset and debug read: hold `rst_n`=0 for 2 edges, then sweep `dbg_idx` 0–F → every read is 0, and `halted`=0.
- irmovq: icode 3, rB=2, `valE`=64'h1234, then one edge → `dbg_data`@2 = 64'h1234. Next cycle: icode 6, rA=2, rB=2 → `srcA`=`srcB`=2 and `valA`=`valB`=64'h1234.
- cmov not taken: icode 2, rB=5, `cnd`=0, `valE`=7, one edge → `dstE`=F and reg5 unchanged. Repeat with `cnd`=1 → reg5=7.
- popq %rsp collision: icode B, rA=4, `valE`=16, `valM`=99, one edge → `dstE`=`dstM`=4 and reg4=99. pushq next cycle: icode A, rA=3 → `srcA`=3, `srcB`=4, `valB`=99.
- Halt sticky: icode 0 for one edge → `halted`=1. Then icode 3, rB=1, `valE`=5 for 3 edges → reg1 unchanged. Pulse `rst_n`=0 for one edge → `halted`=0 and all registers 0.
- Reset mid-write: icode 3, rB=7, `valE`=9 while `rst_n`=0 → reg7 remains 0 after the edge.
